// File: rtl/joy_scan_controller.sv
// Serial joystick chain sequencer: load strobe, shift clock, capture,
// optional two-frame agreement filter and publish with a valid strobe.
module joy_scan_controller #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned IDLE_TICKS = 64,
    parameter int unsigned FILTER     = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable_i,
    input  logic       joy_data_i,
    output logic       joy_clk_o,
    output logic       joy_load_o,
    output logic [7:0] joy1_o,
    output logic [7:0] joy2_o,
    output logic       frame_valid_o,
    output logic       busy_o
);

    localparam int unsigned PW = 8;
    localparam int unsigned WW = 16;
    localparam int unsigned FW = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;

    logic [PW-1:0] pre_q;
    logic          tick;

    logic [2:0]    state_q, state_d;
    logic          load_q, load_d;
    logic          jclk_q, jclk_d;
    logic [3:0]    bit_q, bit_d;
    logic          ldcnt_q, ldcnt_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [FW-1:0] raw_q, raw_d;
    logic [FW-1:0] prev_q, prev_d;
    logic [7:0]    joy1_q, joy1_d;
    logic [7:0]    joy2_q, joy2_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;

    assign tick = (pre_q == PW'(CLK_DIV - 1));

    // Free-running prescaler producing the shift tick
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        jclk_d  = jclk_q;
        bit_d   = bit_q;
        ldcnt_d = ldcnt_q;
        wait_d  = wait_q;
        raw_d   = raw_q;
        prev_d  = prev_q;
        joy1_d  = joy1_q;
        joy2_d  = joy2_q;
        valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                load_d = 1'b1;
                jclk_d = 1'b0;
                if (tick && enable_i) begin
                    state_d = S_LOAD;
                    load_d  = 1'b0;
                    ldcnt_d = 1'b0;
                end
            end
            S_LOAD: begin
                jclk_d = 1'b0;
                if (tick) begin
                    if (ldcnt_q) begin
                        state_d = S_SHIFT;
                        load_d  = 1'b1;
                        bit_d   = 4'd0;
                    end else begin
                        ldcnt_d = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    if (!jclk_q) begin
                        // Sample before the rising edge; first bit lands in the MSB
                        raw_d  = {raw_q[FW-2:0], joy_data_i};
                        jclk_d = 1'b1;
                    end else begin
                        jclk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            state_d = S_COMMIT;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end
            S_COMMIT: begin
                if ((FILTER == 0) || (raw_q == prev_q)) begin
                    joy1_d  = raw_q[15:8];
                    joy2_d  = raw_q[7:0];
                    valid_d = 1'b1;
                end
                prev_d  = raw_q;
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tick) begin
                    if (wait_q == WW'(IDLE_TICKS - 1)) begin
                        if (enable_i) begin
                            state_d = S_LOAD;
                            load_d  = 1'b0;
                            ldcnt_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                load_d  = 1'b1;
                jclk_d  = 1'b0;
            end
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_COMMIT);
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            load_q  <= 1'b1;
            jclk_q  <= 1'b0;
            bit_q   <= '0;
            ldcnt_q <= 1'b0;
            wait_q  <= '0;
            raw_q   <= '1;
            prev_q  <= '1;
            joy1_q  <= 8'hFF;
            joy2_q  <= 8'hFF;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            jclk_q  <= jclk_d;
            bit_q   <= bit_d;
            ldcnt_q <= ldcnt_d;
            wait_q  <= wait_d;
            raw_q   <= raw_d;
            prev_q  <= prev_d;
            joy1_q  <= joy1_d;
            joy2_q  <= joy2_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign joy_clk_o     = jclk_q;
    assign joy_load_o    = load_q;
    assign joy1_o        = joy1_q;
    assign joy2_o        = joy2_q;
    assign frame_valid_o = valid_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_joy_scan_controller.sv
// Bench for joy_scan_controller: one unfiltered and one filtered instance
// share a behavioural 74HC165 chain model.
module tb_joy_scan_controller;

    localparam int unsigned CDIV  = 4;
    localparam int unsigned IDLET = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        jdata;
    logic [15:0] pad = 16'hFFFF;
    logic [15:0] sr = 16'hFFFF;

    logic        jclk0, load0, v0, b0;
    logic [7:0]  j1_0, j2_0;
    logic        jclk1, load1, v1, b1;
    logic [7:0]  j1_1, j2_1;

    int ntests = 0;
    int nfail  = 0;

    int lcnt = 0, rcnt = 0, vcnt0 = 0, vcnt1 = 0;
    int ld_run = 0, ld_last = 0;
    int hi_run = 0, hi_min = 1000, hi_max = 0;
    int lo_run = 0, lo_min = 1000, lo_max = 0;

    // Reference model state
    logic [15:0] exp0 = 16'hFFFF, exp1 = 16'hFFFF, prev1 = 16'hFFFF;
    int ev0 = 0, ev1 = 0;

    always #5 clk = ~clk;

    joy_scan_controller #(.CLK_DIV(CDIV), .IDLE_TICKS(IDLET), .FILTER(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .joy_data_i(jdata),
        .joy_clk_o(jclk0), .joy_load_o(load0), .joy1_o(j1_0), .joy2_o(j2_0),
        .frame_valid_o(v0), .busy_o(b0));

    joy_scan_controller #(.CLK_DIV(CDIV), .IDLE_TICKS(IDLET), .FILTER(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .joy_data_i(jdata),
        .joy_clk_o(jclk1), .joy_load_o(load1), .joy1_o(j1_1), .joy2_o(j2_1),
        .frame_valid_o(v1), .busy_o(b1));

    // Shift-register chain: parallel load while strobe low, shift on rising clock
    always @(negedge load0 or posedge jclk0) begin
        if (!load0) sr <= pad;
        else        sr <= {sr[14:0], 1'b1};
    end
    assign jdata = sr[15];

    always @(negedge load0) lcnt <= lcnt + 1;
    always @(posedge jclk0) rcnt <= rcnt + 1;
    always @(posedge clk) if (v0) vcnt0 <= vcnt0 + 1;
    always @(posedge clk) if (v1) vcnt1 <= vcnt1 + 1;

    // Run-length monitor for load strobe and shift clock phases
    always @(posedge clk) begin
        if (!load0) begin
            ld_run <= ld_run + 1;
        end else begin
            if (ld_run != 0) ld_last <= ld_run;
            ld_run <= 0;
        end
        if (jclk0) begin
            hi_run <= hi_run + 1;
        end else begin
            if (hi_run != 0) begin
                hi_min <= (hi_run < hi_min) ? hi_run : hi_min;
                hi_max <= (hi_run > hi_max) ? hi_run : hi_max;
            end
            hi_run <= 0;
        end
        if (!jclk0 && b0 && load0) begin
            lo_run <= lo_run + 1;
        end else if (jclk0) begin
            if (lo_run != 0) begin
                lo_min <= (lo_run < lo_min) ? lo_run : lo_min;
                lo_max <= (lo_run > lo_max) ? lo_run : lo_max;
            end
            lo_run <= 0;
        end else begin
            lo_run <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_load_start(input int l0);
        bit ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            ok = (lcnt != l0);
        end
        chk("load_start_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_edges(input int r0, input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            ok = ((rcnt - r0) >= n);
        end
        chk("edge_wait_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_frame_end();
        bit ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            ok = (b0 == 1'b0);
        end
        chk("frame_end_timeout", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Apply the publish rules to one completed frame and compare
    task automatic check_frame(input logic [15:0] p, input int r0);
        exp0 = p;
        ev0++;
        if (p == prev1) begin
            exp1 = p;
            ev1++;
        end
        prev1 = p;
        chk("rising_edges", 32'(rcnt - r0), 32'd16);
        chk("valid_cnt_f0", 32'(vcnt0), 32'(ev0));
        chk("valid_cnt_f1", 32'(vcnt1), 32'(ev1));
        chk("pads_f0", {16'h0, j1_0, j2_0}, {16'h0, exp0});
        chk("pads_f1", {16'h0, j1_1, j2_1}, {16'h0, exp1});
        chk("busy_after", 32'(b0), 32'd0);
        chk("inst_align", {30'h0, load1, jclk1}, {30'h0, load0, jclk0});
    endtask

    task automatic run_frame(input logic [15:0] p);
        int l0, r0;
        pad = p;
        l0 = lcnt;
        r0 = rcnt;
        wait_load_start(l0);
        wait_frame_end();
        check_frame(p, r0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_load"}, 32'(load0), 32'd1);
        chk({tag, "_jclk"}, 32'(jclk0), 32'd0);
        chk({tag, "_busy"}, 32'(b0), 32'd0);
        chk({tag, "_valid"}, {30'h0, v1, v0}, 32'd0);
        chk({tag, "_pads0"}, {16'h0, j1_0, j2_0}, 32'h0000FFFF);
        chk({tag, "_pads1"}, {16'h0, j1_1, j2_1}, 32'h0000FFFF);
    endtask

    initial begin
        logic [15:0] p, last;
        int l0, r0, l1, r1;

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Idle with scanning disabled
        repeat (50) @(negedge clk);
        chk("idle_load", 32'(load0), 32'd1);
        chk("idle_lcnt", 32'(lcnt), 32'd0);
        chk("idle_busy", 32'(b0), 32'd0);

        // Capture and strobe timing
        pad = 16'hA55A;
        enable = 1'b1;
        run_frame(16'hA55A);
        chk("load_low_clks", 32'(ld_last), 32'(2 * CDIV));
        chk("clk_hi_min", 32'(hi_min), 32'(CDIV));
        chk("clk_hi_max", 32'(hi_max), 32'(CDIV));
        chk("clk_lo_min", 32'(lo_min), 32'(CDIV));
        chk("clk_lo_max", 32'(lo_max), 32'(CDIV));

        // Filter sequence
        run_frame(16'hFFFE);
        run_frame(16'hFFFE);
        run_frame(16'h7FFE);
        run_frame(16'hFFFE);
        chk("filter_hold", {16'h0, j1_1, j2_1}, 32'h0000FFFE);

        // Stable frames
        run_frame(16'h0000);
        run_frame(16'h0000);
        run_frame(16'h0000);

        // Randomized frames, with repeats to exercise agreement
        last = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            p = ($urandom_range(0, 1) == 0) ? last : 16'($urandom());
            run_frame(p);
            last = p;
        end

        // Enable drop mid-shift
        p = 16'($urandom());
        pad = p;
        l0 = lcnt;
        r0 = rcnt;
        wait_load_start(l0);
        wait_edges(r0, 6);
        enable = 1'b0;
        wait_frame_end();
        check_frame(p, r0);
        l1 = lcnt;
        r1 = rcnt;
        repeat (100) @(negedge clk);
        chk("drop_no_load", 32'(lcnt - l1), 32'd0);
        chk("drop_no_edges", 32'(rcnt - r1), 32'd0);
        chk("drop_load_hi", 32'(load0), 32'd1);
        chk("drop_busy", 32'(b0), 32'd0);
        chk("drop_valid_f0", 32'(vcnt0), 32'(ev0));

        // Reset mid-shift
        enable = 1'b1;
        pad = 16'($urandom());
        l0 = lcnt;
        r0 = rcnt;
        wait_load_start(l0);
        wait_edges(r0, 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (5) @(negedge clk);
        chk("midrst_valid0", 32'(vcnt0), 32'(ev0));
        chk("midrst_valid1", 32'(vcnt1), 32'(ev1));
        exp0 = 16'hFFFF;
        exp1 = 16'hFFFF;
        prev1 = 16'hFFFF;
        rst_n = 1'b1;
        run_frame(16'hFFFF);
        run_frame(16'h1234);

        enable = 1'b0;
        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
